udp_rx_frame_ctrl: RTL and testbench
====================================

UDP_RX_FRAME_CTRL -- requirements
Module: udp_rx_frame_ctrl

Interface
REQ-001 Parameter FRAME_HEAD, default 32'hF3ED7A93, is the frame sync word, matched MSB byte first.
REQ-002 Parameter TOTAL_W, default 25, is the width of the payload byte count.
REQ-003 app_rx_clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 app_rx_data_valid  input  1  qualifies the byte on app_rx_data.
REQ-006 app_rx_data  input  8  is the received UDP payload byte.
REQ-007 app_rx_data_total  input  TOTAL_W  is the frame payload byte count, sampled at header match.
REQ-008 wr_full  input  1  is the downstream 16-bit FIFO full flag.
REQ-009 wr_en  output  1  is the FIFO write strobe.
REQ-010 wr_data  output  16  is the packed payload word.
REQ-011 frame_start  output  1  is a one-cycle pulse marking header detection.
REQ-012 frame_done  output  1  is a one-cycle pulse marking a complete frame.
REQ-013 frame_err  output  1  is a one-cycle pulse marking an aborted frame.
REQ-014 ovf_flag  output  1  is a sticky flag set when a word is dropped on wr_full.

Function
REQ-015 States SHALL be HUNT, PAYLOAD and FLUSH; HUNT is the reset state.
REQ-016 In HUNT, each valid byte SHALL shift into a 32-bit register; valid low SHALL clear the register to 0.
REQ-017 Header match SHALL be register-plus-current-byte == FRAME_HEAD, so overlapping partial headers are found (F3 ED F3 ED 7A 93 matches).
REQ-018 On match, the block SHALL latch app_rx_data_total into remain, pulse frame_start the next cycle, and enter PAYLOAD; if total == 0, it SHALL enter FLUSH instead.
REQ-019 In PAYLOAD, each valid byte SHALL decrement remain; even-index bytes SHALL go to wr_data[15:8] and odd-index bytes to wr_data[7:0].
REQ-020 wr_en SHALL assert one cycle after the odd-index byte is accepted, for exactly one cycle.
REQ-021 If the last byte has an even index (odd total), the low byte SHALL be 8'h00 and wr_en SHALL assert one cycle after that last byte.
REQ-022 When remain reaches 0, the block SHALL enter FLUSH; FLUSH SHALL pulse frame_done for one cycle and return to HUNT with the header register cleared.
REQ-023 frame_done SHALL coincide with, or follow, the final wr_en, never precede it.
REQ-024 If valid deasserts in PAYLOAD with remain != 0, the block SHALL pulse frame_err the next cycle, discard any half-packed byte, and return to HUNT.
REQ-025 If wr_full is high when a word would be written, wr_en SHALL stay low, the word SHALL be dropped, ovf_flag SHALL set, and counting SHALL continue.
REQ-026 ovf_flag SHALL clear only on reset or on the next frame_start.
REQ-027 remain SHALL NOT wrap: it decrements only while non-zero.
REQ-028 No header search SHALL occur in PAYLOAD; payload bytes equal to FRAME_HEAD SHALL be treated as data.

Reset
REQ-029 While rst is high, state SHALL be HUNT, the header register and remain SHALL be 0, and wr_en, wr_data, frame_start, frame_done, frame_err and ovf_flag SHALL all be 0.
REQ-030 Asserting rst mid-frame SHALL abort immediately with no frame_done or frame_err pulse; after release, the block SHALL hunt afresh.

Verification
REQ-031 Bytes 01 02 03 F3 ED 7A 93 then 00..3B, total 60 -> one frame_start, 30 writes 0x0001 .. 0x3A3B, one frame_done, no err.
REQ-032 Bytes F3 ED F3 ED 7A 93 AA BB, total 2 -> match on the 6th byte, one write 0xAABB, frame_done.
REQ-033 Total 5, payload 00..04 -> writes 0x0001, 0x0203, 0x0400, then frame_done.
REQ-034 Total 60 with valid dropped after 11 payload bytes -> 5 writes, frame_err pulse, no frame_done, back in HUNT.
REQ-035 Total 4 with wr_full high during the first word -> only 0x0203 written, ovf_flag=1 held until the next frame_start.
REQ-036 rst pulsed after 20 payload bytes, then a clean 4-byte frame -> all outputs 0 during reset, second frame completes normally.

Source files
------------

// File: rtl/udp_rx_frame_ctrl.sv
// rtl/udp_rx_frame_ctrl.sv - UDP payload framer: sync-word hunt, byte-pair packing to a 16-bit FIFO
module udp_rx_frame_ctrl #(
  parameter logic [31:0] FRAME_HEAD = 32'hF3ED7A93,
  parameter int          TOTAL_W    = 25
) (
  input  logic               app_rx_clk,
  input  logic               rst,
  input  logic               app_rx_data_valid,
  input  logic [7:0]         app_rx_data,
  input  logic [TOTAL_W-1:0] app_rx_data_total,
  input  logic               wr_full,
  output logic               wr_en,
  output logic [15:0]        wr_data,
  output logic               frame_start,
  output logic               frame_done,
  output logic               frame_err,
  output logic               ovf_flag
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, FLUSH} state_t;

  state_t             state;
  // Only the three most recent bytes are kept; the fourth is the byte on the bus.
  logic [23:0]        head;
  logic [TOTAL_W-1:0] remain;
  logic [7:0]         hi_byte;
  logic               odd;

  logic [31:0] shifted;
  logic        last_byte;
  logic        word_now;
  logic [15:0] word;

  always_comb begin
    shifted   = {head, app_rx_data};
    last_byte = (remain == TOTAL_W'(1));
    word_now  = 1'b0;
    word      = 16'h0000;
    if (state == PAYLOAD && app_rx_data_valid) begin
      word_now = odd || last_byte;
      word     = odd ? {hi_byte, app_rx_data} : {app_rx_data, 8'h00};
    end
  end

  always_ff @(posedge app_rx_clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      head        <= '0;
      remain      <= '0;
      hi_byte     <= '0;
      odd         <= 1'b0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      ovf_flag    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;

      if (word_now) begin
        if (wr_full) begin
          ovf_flag <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_data <= word;
        end
      end

      case (state)
        HUNT: begin
          if (!app_rx_data_valid) begin
            head <= '0;
          end else if (shifted == FRAME_HEAD) begin
            head        <= '0;
            remain      <= app_rx_data_total;
            odd         <= 1'b0;
            hi_byte     <= '0;
            frame_start <= 1'b1;
            ovf_flag    <= 1'b0;
            state       <= (app_rx_data_total == '0) ? FLUSH : PAYLOAD;
          end else begin
            head <= shifted[23:0];
          end
        end
        PAYLOAD: begin
          if (app_rx_data_valid) begin
            if (remain != '0) remain <= remain - TOTAL_W'(1);
            odd <= ~odd;
            if (!odd) hi_byte <= app_rx_data;
            if (last_byte) state <= FLUSH;
          end else begin
            // Gap mid-frame: drop any half-packed byte and resynchronise.
            frame_err <= 1'b1;
            odd       <= 1'b0;
            hi_byte   <= '0;
            remain    <= '0;
            state     <= HUNT;
          end
        end
        FLUSH: begin
          frame_done <= 1'b1;
          head       <= '0;
          odd        <= 1'b0;
          state      <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_ctrl.sv
// tb/tb_udp_rx_frame_ctrl.sv - directed self-checking bench for udp_rx_frame_ctrl
module tb_udp_rx_frame_ctrl;

  logic        app_rx_clk = 1'b0;
  logic        rst = 1'b1;
  logic        app_rx_data_valid = 1'b0;
  logic [7:0]  app_rx_data = 8'h00;
  logic [24:0] app_rx_data_total = '0;
  logic        wr_full = 1'b0;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        frame_start, frame_done, frame_err, ovf_flag;

  udp_rx_frame_ctrl dut (
    .app_rx_clk        (app_rx_clk),
    .rst               (rst),
    .app_rx_data_valid (app_rx_data_valid),
    .app_rx_data       (app_rx_data),
    .app_rx_data_total (app_rx_data_total),
    .wr_full           (wr_full),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .frame_start       (frame_start),
    .frame_done        (frame_done),
    .frame_err         (frame_err),
    .ovf_flag          (ovf_flag)
  );

  always #5 app_rx_clk = ~app_rx_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wq[$];
  int cyc = 0, last_wr = 0, done_cyc = 0;
  int n_start = 0, n_done = 0, n_errp = 0;

  always @(negedge app_rx_clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      wq.push_back(wr_data);
      last_wr <= cyc;
    end
    if (frame_start) n_start <= n_start + 1;
    if (frame_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (frame_err) n_errp <= n_errp + 1;
  end

  int b_wr, b_start, b_done, b_err;

  task automatic mark();
    b_wr = wq.size(); b_start = n_start; b_done = n_done; b_err = n_errp;
  endtask

  task automatic put(input logic v, input logic [7:0] b);
    app_rx_data_valid = v;
    app_rx_data       = b;
    @(posedge app_rx_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 8'h00);
  endtask

  task automatic send_head(input int total);
    app_rx_data_total = 25'(total);
    put(1'b1, 8'hF3); put(1'b1, 8'hED); put(1'b1, 8'h7A); put(1'b1, 8'h93);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge app_rx_clk);
    #1;
    n_cmp++;
    if ({wr_en, wr_data, frame_start, frame_done, frame_err, ovf_flag} !== 21'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {wr_en, wr_data, frame_start, frame_done, frame_err, ovf_flag});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    mark();
    put(1'b1, 8'h01); put(1'b1, 8'h02); put(1'b1, 8'h03);
    send_head(60);
    for (int i = 0; i < 60; i++) put(1'b1, 8'(i));
    idle(4);
    n_cmp++;
    if (n_start - b_start !== 1) begin n_bad++; $display("FAIL basic_start: got %0d want 1", n_start - b_start); end
    n_cmp++;
    if (wq.size() - b_wr !== 30) begin n_bad++; $display("FAIL basic_nwr: got %0d want 30", wq.size() - b_wr); end
    for (int i = 0; i < 30 && b_wr + i < wq.size(); i++) begin
      n_cmp++;
      if (wq[b_wr + i] !== {8'(2 * i), 8'(2 * i + 1)}) begin
        n_bad++;
        $display("FAIL basic_word%0d: got %h want %h", i, wq[b_wr + i], {8'(2 * i), 8'(2 * i + 1)});
      end
    end
    n_cmp++;
    if (n_done - b_done !== 1) begin n_bad++; $display("FAIL basic_done: got %0d want 1", n_done - b_done); end
    n_cmp++;
    if (n_errp - b_err !== 0) begin n_bad++; $display("FAIL basic_err: got %0d want 0", n_errp - b_err); end
    n_cmp++;
    if (done_cyc < last_wr) begin n_bad++; $display("FAIL basic_order: done cyc %0d before last wr cyc %0d", done_cyc, last_wr); end
  endtask

  task automatic test_overlap();
    mark();
    app_rx_data_total = 25'd2;
    put(1'b1, 8'hF3); put(1'b1, 8'hED); put(1'b1, 8'hF3); put(1'b1, 8'hED); put(1'b1, 8'h7A);
    n_cmp++;
    if (frame_start !== 1'b0) begin n_bad++; $display("FAIL ovl_early_start: got %b want 0", frame_start); end
    put(1'b1, 8'h93);
    n_cmp++;
    if (frame_start !== 1'b1) begin n_bad++; $display("FAIL ovl_start: got %b want 1", frame_start); end
    put(1'b1, 8'hAA); put(1'b1, 8'hBB);
    idle(4);
    n_cmp++;
    if (wq.size() - b_wr !== 1) begin n_bad++; $display("FAIL ovl_nwr: got %0d want 1", wq.size() - b_wr); end
    else begin
      n_cmp++;
      if (wq[b_wr] !== 16'hAABB) begin n_bad++; $display("FAIL ovl_word: got %h want aabb", wq[b_wr]); end
    end
    n_cmp++;
    if (n_done - b_done !== 1) begin n_bad++; $display("FAIL ovl_done: got %0d want 1", n_done - b_done); end
  endtask

  task automatic test_odd_total();
    logic [15:0] exp [3];
    exp[0] = 16'h0001; exp[1] = 16'h0203; exp[2] = 16'h0400;
    mark();
    send_head(5);
    for (int i = 0; i < 5; i++) put(1'b1, 8'(i));
    idle(4);
    n_cmp++;
    if (wq.size() - b_wr !== 3) begin n_bad++; $display("FAIL odd_nwr: got %0d want 3", wq.size() - b_wr); end
    for (int i = 0; i < 3 && b_wr + i < wq.size(); i++) begin
      n_cmp++;
      if (wq[b_wr + i] !== exp[i]) begin n_bad++; $display("FAIL odd_word%0d: got %h want %h", i, wq[b_wr + i], exp[i]); end
    end
    n_cmp++;
    if (n_done - b_done !== 1) begin n_bad++; $display("FAIL odd_done: got %0d want 1", n_done - b_done); end
    n_cmp++;
    if (done_cyc < last_wr) begin n_bad++; $display("FAIL odd_order: done cyc %0d before last wr cyc %0d", done_cyc, last_wr); end
  endtask

  task automatic test_abort();
    mark();
    send_head(60);
    for (int i = 0; i < 11; i++) put(1'b1, 8'(i));
    idle(4);
    n_cmp++;
    if (wq.size() - b_wr !== 5) begin n_bad++; $display("FAIL abort_nwr: got %0d want 5", wq.size() - b_wr); end
    n_cmp++;
    if (n_errp - b_err !== 1) begin n_bad++; $display("FAIL abort_err: got %0d want 1", n_errp - b_err); end
    n_cmp++;
    if (n_done - b_done !== 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", n_done - b_done); end
    // Back in HUNT: a fresh 2-byte frame must be found.
    mark();
    send_head(2); put(1'b1, 8'h12); put(1'b1, 8'h34);
    idle(4);
    n_cmp++;
    if (wq.size() - b_wr !== 1 || wq[wq.size() - 1] !== 16'h1234) begin
      n_bad++; $display("FAIL abort_rehunt: got %0d writes last %h want 1 write 1234", wq.size() - b_wr, wq[wq.size() - 1]);
    end
  endtask

  task automatic test_overflow();
    mark();
    send_head(4);
    wr_full = 1'b1;
    put(1'b1, 8'h00); put(1'b1, 8'h01);
    wr_full = 1'b0;
    put(1'b1, 8'h02); put(1'b1, 8'h03);
    idle(6);
    n_cmp++;
    if (wq.size() - b_wr !== 1) begin n_bad++; $display("FAIL ovf_nwr: got %0d want 1", wq.size() - b_wr); end
    else begin
      n_cmp++;
      if (wq[b_wr] !== 16'h0203) begin n_bad++; $display("FAIL ovf_word: got %h want 0203", wq[b_wr]); end
    end
    n_cmp++;
    if (ovf_flag !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_flag); end
    n_cmp++;
    if (n_done - b_done !== 1) begin n_bad++; $display("FAIL ovf_done: got %0d want 1", n_done - b_done); end
    // Zero-length frame: start clears ovf, done follows with no writes.
    mark();
    send_head(0);
    n_cmp++;
    if ({frame_start, ovf_flag} !== 2'b10) begin n_bad++; $display("FAIL ovf_clear: got start,ovf=%b want 10", {frame_start, ovf_flag}); end
    idle(3);
    n_cmp++;
    if (n_done - b_done !== 1 || wq.size() != b_wr) begin
      n_bad++; $display("FAIL zero_total: got done %0d writes %0d want 1 and 0", n_done - b_done, wq.size() - b_wr);
    end
  endtask

  task automatic test_head_in_payload();
    mark();
    send_head(4);
    put(1'b1, 8'hF3); put(1'b1, 8'hED); put(1'b1, 8'h7A); put(1'b1, 8'h93);
    idle(4);
    n_cmp++;
    if (n_start - b_start !== 1) begin n_bad++; $display("FAIL hip_start: got %0d want 1", n_start - b_start); end
    n_cmp++;
    if (wq.size() - b_wr !== 2 || wq[wq.size() - 2] !== 16'hF3ED || wq[wq.size() - 1] !== 16'h7A93) begin
      n_bad++; $display("FAIL hip_words: got %0d writes want f3ed 7a93", wq.size() - b_wr);
    end
  endtask

  task automatic test_mid_reset();
    mark();
    wr_full = 1'b1;
    send_head(60);
    for (int i = 0; i < 20; i++) put(1'b1, 8'(i));
    wr_full = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, wr_data, frame_start, frame_done, frame_err, ovf_flag} !== 21'h0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %h want 0", {wr_en, wr_data, frame_start, frame_done, frame_err, ovf_flag});
    end
    idle(3);
    rst = 1'b0;
    idle(2);
    n_cmp++;
    if (n_done - b_done !== 0 || n_errp - b_err !== 0) begin
      n_bad++; $display("FAIL midrst_pulses: got done %0d err %0d want 0 0", n_done - b_done, n_errp - b_err);
    end
    mark();
    send_head(4);
    for (int i = 0; i < 4; i++) put(1'b1, 8'(i));
    idle(4);
    n_cmp++;
    if (wq.size() - b_wr !== 2 || wq[wq.size() - 2] !== 16'h0001 || wq[wq.size() - 1] !== 16'h0203) begin
      n_bad++; $display("FAIL midrst_words: got %0d writes want 0001 0203", wq.size() - b_wr);
    end
    n_cmp++;
    if (n_done - b_done !== 1 || n_errp - b_err !== 0) begin
      n_bad++; $display("FAIL midrst_done: got done %0d err %0d want 1 0", n_done - b_done, n_errp - b_err);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_overlap();
    test_odd_total();
    test_abort();
    test_overflow();
    test_head_in_payload();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
